// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants, depth helper
// and the default pointer/count type.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Pointers carry one extra bit so occupancy 0..DEPTH is representable.
    typedef logic [DEFAULT_ADDR_WIDTH:0] fifo_ptr_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Dual-port register file for the FIFO: synchronous write, asynchronous read,
// contents are never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int Data_width = 8,
    parameter int Addr_width = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [Addr_width-1:0] i_wr_addr,
    input  logic [Data_width-1:0] i_wr_data,
    input  logic [Addr_width-1:0] i_rd_addr,
    output logic [Data_width-1:0] o_rd_data
);

    localparam int DEPTH = fifo_depth(Addr_width);

    logic [Data_width-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a choice of registered or fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int Data_width      = 8,
    parameter int Addr_width      = DEFAULT_ADDR_WIDTH,
    parameter int Almost_full_th  = fifo_depth(Addr_width) - 4,
    parameter int Almost_empty_th = 4,
    parameter int FWFT            = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Wr_en,
    input  logic [Data_width-1:0] Wr_data,
    input  logic                  Rd_en,
    output logic [Data_width-1:0] Rd_data,
    output logic                  Rd_valid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_full,
    output logic                  Almost_empty,
    output logic [Addr_width:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int DEPTH = fifo_depth(Addr_width);

    typedef logic [Addr_width:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_TH   = ptr_t'(Almost_full_th);
    localparam ptr_t AE_TH   = ptr_t'(Almost_empty_th);

    if (Addr_width < 1 || Almost_full_th < 1 || Almost_full_th > DEPTH ||
        Almost_empty_th < 0 || Almost_empty_th > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_flags: unsupported parameter values");
    end

    ptr_t                  r_wr_ptr;
    ptr_t                  r_rd_ptr;
    ptr_t                  r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [Data_width-1:0] w_mem_rd_data;
    logic                  w_unused;

    assign w_full   = (r_count == DEPTH_P);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = Wr_en & ~w_full;
    assign w_rd_acc = Rd_en & ~w_empty;

    // Flags come from the registered count only, so they cannot glitch on inputs.
    assign Full         = w_full;
    assign Empty        = w_empty;
    assign Almost_full  = (r_count >= AF_TH);
    assign Almost_empty = (r_count <= AE_TH);
    assign Count        = r_count;
    assign Overflow     = r_overflow;
    assign Underflow    = r_underflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + ptr_t'(1);
                2'b01:   r_count <= r_count - ptr_t'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= Wr_en & w_full;
            r_underflow <= Rd_en & w_empty;
        end
    end

    fifo_mem #(
        .Data_width (Data_width),
        .Addr_width (Addr_width)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[Addr_width-1:0]),
        .i_wr_data (Wr_data),
        .i_rd_addr (r_rd_ptr[Addr_width-1:0]),
        .o_rd_data (w_mem_rd_data)
    );

    // Pointer MSBs only keep the pointers in the count's number range.
    assign w_unused = ^{r_wr_ptr[Addr_width], r_rd_ptr[Addr_width]};

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign Rd_data  = w_mem_rd_data;
        assign Rd_valid = ~w_empty;
    end else begin : g_std
        logic [Data_width-1:0] r_rd_data;
        logic                  r_rd_valid;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= w_mem_rd_data;
                end
            end
        end

        assign Rd_data  = r_rd_data;
        assign Rd_valid = r_rd_valid;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-mode and a fall-through FIFO with identical stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Wr_en = 1'b0;
    logic          Rd_en = 1'b0;
    logic [DW-1:0] Wr_data = '0;

    logic [DW-1:0] s_data, f_data;
    logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [AW:0]   s_count, f_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] expStdData = '0;
    logic          expStdValid = 1'b0;
    logic          expOvf = 1'b0;
    logic          expUnf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .Data_width (DW), .Addr_width (AW), .Almost_full_th (AF_TH),
        .Almost_empty_th (AE_TH), .FWFT (0)
    ) u_std (
        .clk (clk), .rst (rst), .Wr_en (Wr_en), .Wr_data (Wr_data), .Rd_en (Rd_en),
        .Rd_data (s_data), .Rd_valid (s_valid), .Full (s_full), .Empty (s_empty),
        .Almost_full (s_af), .Almost_empty (s_ae), .Count (s_count),
        .Overflow (s_ovf), .Underflow (s_unf)
    );

    sync_fifo_flags #(
        .Data_width (DW), .Addr_width (AW), .Almost_full_th (AF_TH),
        .Almost_empty_th (AE_TH), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .Wr_en (Wr_en), .Wr_data (Wr_data), .Rd_en (Rd_en),
        .Rd_data (f_data), .Rd_valid (f_valid), .Full (f_full), .Empty (f_empty),
        .Almost_full (f_af), .Almost_empty (f_ae), .Count (f_count),
        .Overflow (f_ovf), .Underflow (f_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int n = q.size();
        check("s_count", 32'(s_count), n);
        check("f_count", 32'(f_count), n);
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("s_full", 32'(s_full), 32'(n == DEPTH));
        check("f_full", 32'(f_full), 32'(n == DEPTH));
        check("s_almost_full", 32'(s_af), 32'(n >= AF_TH));
        check("f_almost_full", 32'(f_af), 32'(n >= AF_TH));
        check("s_almost_empty", 32'(s_ae), 32'(n <= AE_TH));
        check("f_almost_empty", 32'(f_ae), 32'(n <= AE_TH));
        check("s_overflow", 32'(s_ovf), 32'(expOvf));
        check("f_overflow", 32'(f_ovf), 32'(expOvf));
        check("s_underflow", 32'(s_unf), 32'(expUnf));
        check("f_underflow", 32'(f_unf), 32'(expUnf));
        check("s_rd_valid", 32'(s_valid), 32'(expStdValid));
        check("s_rd_data", 32'(s_data), 32'(expStdData));
        check("f_rd_valid", 32'(f_valid), 32'(n > 0));
        if (n > 0) begin
            check("f_rd_data", 32'(f_data), 32'(q[0]));
        end
    endtask

    // Called at a falling edge; applies inputs for one rising edge, then checks.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] din, input logic rd);
        int  n;
        logic wrAcc, rdAcc;
        Wr_en   = wr;
        Wr_data = din;
        Rd_en   = rd;
        @(posedge clk);
        n     = q.size();
        wrAcc = wr && (n < DEPTH);
        rdAcc = rd && (n > 0);
        expOvf      = wr && !wrAcc;
        expUnf      = rd && !rdAcc;
        expStdValid = rdAcc;
        if (rdAcc) expStdData = q.pop_front();
        if (wrAcc) q.push_back(din);
        @(negedge clk);
        Wr_en = 1'b0;
        Rd_en = 1'b0;
        checkOutput();
    endtask

    task automatic modelReset();
        q.delete();
        expStdData  = '0;
        expStdValid = 1'b0;
        expOvf      = 1'b0;
        expUnf      = 1'b0;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        checkOutput();
        rst = 1'b1;
        @(negedge clk);
        checkOutput();
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Standard fill and drain, flags checked at every occupancy
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Overflow on full, underflow on empty
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Simultaneous write and read at full and mid occupancy, then at empty
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h66, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Fall-through visibility of a single word
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Random interleaving exercising pointer wrap
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with five words stored
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("s_count_async_rst", 32'(s_count), 0);
        check("f_count_async_rst", 32'(f_count), 0);
        check("s_empty_async_rst", 32'(s_empty), 1);
        check("f_empty_async_rst", 32'(f_empty), 1);
        modelReset();
        @(negedge clk);
        checkOutput();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
